serial_subtractor: RTL and testbench

//   Bit-serial, LSB-first subtractor: computes DIFF = A - B - BIN over WIDTH bits.
//   It reuses one full-subtractor cell per clock and registers the borrow between cycles.
//   It is the subtraction counterpart of the ripple-adder datapath.
//   It sits beside the adders in the arithmetic block and trades latency for area.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_if.sv | 32 +++
 rtl/serial_subtractor_bitsubtractor.sv | 17 +
 rtl/serial_subtractor.sv | 98 +++++++++
 tb/tb_serial_subtractor.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// serial_subtractor_pkg
//   Shared FSM encodings and default width for the bit-serial subtractor.
//   Revision: 1.0
// ============================================================================
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// serial_subtractor_if
//   Request/result bundle between a requester and the serial subtractor.
//   Revision: 1.0
// ============================================================================
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, borrow_out, overflow
    );
endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor_bitsubtractor.sv
`default_nettype none
// ============================================================================
// bitsubtractor
//   Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow.
//   Revision: 1.0
// ============================================================================
module bitsubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule : bitsubtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor
//   LSB-first bit-serial subtractor computing (a - b - bin) mod 2^WIDTH.
//   Revision: 1.0
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             brw;
    logic             busy_r;
    logic             done_r;
    logic             bout_r;
    logic             ovf_r;
    logic             d;
    logic             bout;

    bitsubtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                // DONE accepts a new request exactly like IDLE (back-to-back issue)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        brw    <= bus.bin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_SHIFT;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {d, res[WIDTH-1:1]};
                    brw  <= bout;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Last cell sees the operand MSBs and produces the result MSB
                        bout_r <= bout;
                        ovf_r  <= (a_sh[0] ^ b_sh[0]) & (d ^ a_sh[0]);
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.diff       = res;
    assign bus.borrow_out = bout_r;
    assign bus.overflow   = ovf_r;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor at WIDTH=8.
//   Revision: 1.0
// ============================================================================
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the start edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic bin, input logic [7:0] ed, input logic eb,
                           input logic eo);
        int lat;
        issue(a, b, bin);
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(lat);
        check({tag, ".lat"}, 64'(lat), 64'd8);
        check({tag, ".diff"}, 64'(bus.diff), 64'(ed));
        check({tag, ".bout"}, 64'(bus.borrow_out), 64'(eb));
        check({tag, ".ovf"}, 64'(bus.overflow), 64'(eo));
        @(negedge clk);
        check({tag, ".done_clr"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int pulses;
        logic [7:0] seen;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.diff", 64'(bus.diff), 64'd0);
        check("rst.bout", 64'(bus.borrow_out), 64'd0);
        check("rst.ovf",  64'(bus.overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec("v1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_vec("v2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_vec("v3", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_vec("v4", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_vec("v5", 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0);
        run_vec("v6", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_vec("v7", 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);

        // Start pulses while busy must be ignored; operand changes too.
        pulses = 0;
        seen   = '0;
        issue(8'h05, 8'h03, 1'b0);
        bus.a = 8'hAA;
        bus.b = 8'h11;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            bus.start = (cyc == 2 || cyc == 5);
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                seen = bus.diff;
            end
        end
        bus.start = 1'b0;
        check("ign.pulses", 64'(pulses), 64'd1);
        check("ign.diff", 64'(seen), 64'h02);

        // Asynchronous reset in the middle of a shift aborts silently.
        issue(8'hFF, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", 64'(bus.busy), 64'd0);
        check("arst.diff", 64'(bus.diff), 64'd0);
        check("arst.bout", 64'(bus.borrow_out), 64'd0);
        check("arst.ovf",  64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("arst.nodone", 64'(pulses), 64'd0);
        run_vec("post", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // Start during the DONE cycle launches the next operation back-to-back.
        issue(8'h05, 8'h03, 1'b0);
        wait_done(lat);
        check("b2b.lat1", 64'(lat), 64'd8);
        check("b2b.diff1", 64'(bus.diff), 64'h02);
        issue(8'h03, 8'h05, 1'b0);
        check("b2b.busy", 64'(bus.busy), 64'd1);
        check("b2b.done_clr", 64'(bus.done), 64'd0);
        wait_done(lat);
        check("b2b.lat2", 64'(lat), 64'd8);
        check("b2b.diff2", 64'(bus.diff), 64'hFE);
        check("b2b.bout2", 64'(bus.borrow_out), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule : tb_serial_subtractor
`default_nettype wire
